// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_LZ_BLANK_EN to register leading-zero blanking onto dig_en.
module bin2bcd_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         ready,
  output logic         done_tick,
  output logic [3:0]   bcd2,
  output logic [3:0]   bcd1,
  output logic [3:0]   bcd0,
  output logic [2:0]   dig_en
);
  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [W-1:0] p_q, p_d;
  logic [3:0] b2_q, b2_d, b1_q, b1_d, b0_q, b0_d;
  logic [3:0] bcd2_q, bcd2_d, bcd1_q, bcd1_d, bcd0_q, bcd0_d;
  logic [3:0] a2, a1, a0;
  logic [W+11:0] sh;
  always_comb begin
    a2 = (b2_q >= 4'd5) ? b2_q + 4'd3 : b2_q;
    a1 = (b1_q >= 4'd5) ? b1_q + 4'd3 : b1_q;
    a0 = (b0_q >= 4'd5) ? b0_q + 4'd3 : b0_q;
    sh = {a2, a1, a0, p_q} << 1;
    state_d = state_q;
    n_d = n_q;
    p_d = p_q;
    b2_d = b2_q;
    b1_d = b1_q;
    b0_d = b0_q;
    bcd2_d = bcd2_q;
    bcd1_d = bcd1_q;
    bcd0_d = bcd0_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = OP;
        p_d = bin;
        {b2_d, b1_d, b0_d} = '0;
        n_d = 4'(W);
      end
      OP: begin
        {b2_d, b1_d, b0_d, p_d} = sh;
        n_d = n_q - 4'd1;
        if (n_q == 4'd1) begin
          state_d = DONE;
          {bcd2_d, bcd1_d, bcd0_d} = sh[W+11:W];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      p_q <= '0;
      {b2_q, b1_q, b0_q} <= '0;
      {bcd2_q, bcd1_q, bcd0_q} <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      p_q <= p_d;
      {b2_q, b1_q, b0_q} <= {b2_d, b1_d, b0_d};
      {bcd2_q, bcd1_q, bcd0_q} <= {bcd2_d, bcd1_d, bcd0_d};
    end
  end
  assign ready = state_q == IDLE;
  assign done_tick = state_q == DONE;
  assign bcd2 = bcd2_q;
  assign bcd1 = bcd1_q;
  assign bcd0 = bcd0_q;
`ifdef BIN2BCD_LZ_BLANK_EN
  logic [2:0] dig_en_q, dig_en_d;
  assign dig_en_d = {|bcd2_d, |{bcd2_d, bcd1_d}, 1'b1};
  always_ff @(posedge clk) begin
    if (rst) dig_en_q <= 3'b001;
    else dig_en_q <= dig_en_d;
  end
  assign dig_en = dig_en_q;
`else
  assign dig_en = 3'b111;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed scoreboard bench for bin2bcd_seq (W=8 and W=9 instances).
module tb_bin2bcd_seq;
  logic clk, rst, s8, s9;
  logic [7:0] bin8;
  logic [8:0] bin9;
  logic r8, d8, r9, d9;
  logic [3:0] h8, t8, o8, h9, t9, o9;
  logic [2:0] e8, e9;
  logic [14:0] exp_q[$];
  int ncmp = 0, nfail = 0;

  bin2bcd_seq #(.W(8)) u8 (.clk(clk), .rst(rst), .start(s8), .bin(bin8), .ready(r8), .done_tick(d8),
    .bcd2(h8), .bcd1(t8), .bcd0(o8), .dig_en(e8));
  bin2bcd_seq #(.W(9)) u9 (.clk(clk), .rst(rst), .start(s9), .bin(bin9), .ready(r9), .done_tick(d9),
    .bcd2(h9), .bcd1(t9), .bcd0(o9), .dig_en(e9));

  initial clk = 0;
  always #5 clk = ~clk;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam logic [2:0] DE_RST = 3'b001;
`else
  localparam logic [2:0] DE_RST = 3'b111;
`endif

  function automatic logic [14:0] ref_val(input int v);
    int h, t, o;
    logic [2:0] de;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
`ifdef BIN2BCD_LZ_BLANK_EN
    de = {h != 0, (h != 0) || (t != 0), 1'b1};
`else
    de = 3'b111;
`endif
    return {h[3:0], t[3:0], o[3:0], de};
  endfunction

  function automatic logic [14:0] out_of(input int sel);
    return sel == 9 ? {h9, t9, o9, e9} : {h8, t8, o8, e8};
  endfunction
  function automatic logic ready_of(input int sel);
    return sel == 9 ? r9 : r8;
  endfunction
  function automatic logic done_of(input int sel);
    return sel == 9 ? d9 : d8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input int v, input logic s);
    if (sel == 9) begin bin9 = v[8:0]; s9 = s; end
    else begin bin8 = v[7:0]; s8 = s; end
  endtask

  task automatic pulse(input int sel, input int v);
    @(posedge clk); #1 drive(sel, v, 1'b1);
    @(posedge clk); #1 drive(sel, int'($urandom), 1'b0);
  endtask

  task automatic wait_done(input int sel, input int lim, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!done_of(sel) && cyc < lim);
  endtask

  task automatic pop_cmp(input int sel, input string tag);
    logic [14:0] e;
    chk({tag, " qsize"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " digits"}, out_of(sel), e);
    end
  endtask

  task automatic run(input int sel, input int v, input string tag);
    int cyc;
    exp_q.push_back(ref_val(v));
    pulse(sel, v);
    @(negedge clk);
    chk({tag, " busy"}, ready_of(sel), 0);
    wait_done(sel, 20, cyc);
    chk({tag, " latency"}, cyc, sel);
    pop_cmp(sel, tag);
    @(negedge clk);
    chk({tag, " ready"}, ready_of(sel), 1);
    chk({tag, " done_low"}, done_of(sel), 0);
  endtask

  initial begin
    int cyc, nd;
    rst = 1; s8 = 0; s9 = 0; bin8 = 0; bin9 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst ready", r8, 1);
    chk("rst done", d8, 0);
    chk("rst out", out_of(8), {12'h000, DE_RST});
    chk("rst out9", out_of(9), {12'h000, DE_RST});

    run(8, 255, "max");
    run(8, 0, "zero");

    // second start lands in OP and must be dropped
    exp_q.push_back(ref_val(100));
    pulse(8, 100);
    repeat (3) @(posedge clk);
    #1 drive(8, 7, 1'b1);
    @(posedge clk); #1 drive(8, 0, 1'b0);
    wait_done(8, 20, cyc);
    chk("busy latency", cyc, 4);
    pop_cmp(8, "busy");
    nd = 0;
    repeat (15) begin @(negedge clk); if (d8) nd++; end
    chk("busy extra_done", nd, 0);

    // start held high: DONE ignores it, IDLE takes it
    @(posedge clk); #1 drive(8, 42, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ref_val(42));
      wait_done(8, 20, cyc);
      chk("held spacing", cyc, k == 0 ? 8 : 10);
      pop_cmp(8, "held");
    end
    @(posedge clk); #1 drive(8, 0, 1'b0);
    repeat (3) @(posedge clk);

    pulse(8, 99);
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort ready", r8, 1);
    chk("abort done", d8, 0);
    chk("abort out", out_of(8), {12'h000, DE_RST});
    nd = 0;
    repeat (15) begin @(negedge clk); if (d8) nd++; end
    chk("abort no_done", nd, 0);
    chk("abort hold", out_of(8), {12'h000, DE_RST});
    run(8, 9, "post_rst");

    run(9, 511, "w9 max");
    run(9, 300, "w9 mid");
    for (int v = 0; v < 256; v++) run(8, v, "exh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
